// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, branch and memory-wait hazard control for a 5-stage pipeline.
// Optional statistics counters are enabled by defining PIPE_HAZARD_STATS_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_WAIT_MAX = 16,
    parameter int STAT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              IDEX_MemRead_i,
    input  logic [4:0]        IDEX_RDaddr_i,
    input  logic [4:0]        IFID_RS1addr_i,
    input  logic [4:0]        IFID_RS2addr_i,
    input  logic              Branch_taken_i,
    input  logic              mem_busy_i,
    output logic              PCWrite_o,
    output logic              IFID_Write_o,
    output logic              IFID_Flush_o,
    output logic              IDEX_Bubble_o,
    output logic              freeze_o,
    output logic              timeout_o,
`ifdef PIPE_HAZARD_STATS_EN
    output logic [STAT_W-1:0] stall_cnt_o,
    output logic [STAT_W-1:0] flush_cnt_o,
    output logic [STAT_W-1:0] freeze_cnt_o,
`endif
    output logic [1:0]        state_o
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] HALT     = 2'd2;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    if (MEM_WAIT_MAX < 2 || MEM_WAIT_MAX > 255 || STAT_W < 1) begin : g_param_chk
        $error("pipe_hazard_ctrl: MEM_WAIT_MAX must be 2..255 and STAT_W >= 1");
    end

    logic [1:0] state_q, state_d;
    logic [7:0] busy_cnt_q, busy_cnt_d;
    logic       load_use, halt, busy_ev, lu_ev, br_ev;

    assign load_use = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
                      (IDEX_RDaddr_i == IFID_RS1addr_i || IDEX_RDaddr_i == IFID_RS2addr_i);
    assign halt     = state_q == HALT;
    assign busy_ev  = !halt && mem_busy_i;
    assign lu_ev    = !halt && !mem_busy_i && load_use;
    assign br_ev    = !halt && !mem_busy_i && !load_use && Branch_taken_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            busy_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // busy_cnt_q holds the number of consecutive busy cycles seen, including the RUN cycle that started the wait
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        case (state_q)
            RUN: begin
                state_d    = mem_busy_i ? MEM_WAIT : RUN;
                busy_cnt_d = mem_busy_i ? 8'd1 : 8'd0;
            end
            MEM_WAIT: begin
                state_d    = !mem_busy_i ? RUN : (busy_cnt_q == WAIT_LAST) ? HALT : MEM_WAIT;
                busy_cnt_d = mem_busy_i ? busy_cnt_q + 8'd1 : 8'd0;
            end
            HALT: state_d = HALT;
            default: begin
                state_d    = RUN;
                busy_cnt_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        PCWrite_o     = rst_i ? 1'b0 : !(halt || busy_ev || lu_ev);
        IFID_Write_o  = rst_i ? 1'b0 : !(halt || busy_ev || lu_ev);
        IFID_Flush_o  = !rst_i && br_ev;
        IDEX_Bubble_o = rst_i || lu_ev;
        freeze_o      = !rst_i && (halt || busy_ev);
        timeout_o     = halt;
        state_o       = state_q;
    end

`ifdef PIPE_HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (lu_ev && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + STAT_W'(1);
            if (br_ev && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + STAT_W'(1);
            if ((halt || busy_ev) && !(&freeze_cnt_q)) freeze_cnt_q <= freeze_cnt_q + STAT_W'(1);
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
    assign freeze_cnt_o = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table vectors, hand sequences and random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MAXW = 4;

    typedef struct packed {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       busy;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [7:0] exp;
    } vec_t;

    logic clk_i = 1'b0, rst_i = 1'b1;
    logic IDEX_MemRead_i = 1'b0, Branch_taken_i = 1'b0, mem_busy_i = 1'b0;
    logic [4:0] IDEX_RDaddr_i = '0, IFID_RS1addr_i = '0, IFID_RS2addr_i = '0;
    logic PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, freeze_o, timeout_o;
    logic [1:0] state_o;
    logic [7:0] dut_out;
`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stall_cnt_o, flush_cnt_o, freeze_cnt_o;
`endif

    pipe_hazard_ctrl #(.MEM_WAIT_MAX(MAXW), .STAT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RDaddr_i(IDEX_RDaddr_i),
        .IFID_RS1addr_i(IFID_RS1addr_i), .IFID_RS2addr_i(IFID_RS2addr_i),
        .Branch_taken_i(Branch_taken_i), .mem_busy_i(mem_busy_i),
        .PCWrite_o(PCWrite_o), .IFID_Write_o(IFID_Write_o), .IFID_Flush_o(IFID_Flush_o),
        .IDEX_Bubble_o(IDEX_Bubble_o), .freeze_o(freeze_o), .timeout_o(timeout_o),
`ifdef PIPE_HAZARD_STATS_EN
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .freeze_cnt_o(freeze_cnt_o),
`endif
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    // {PCWrite, IFID_Write, Flush, Bubble, freeze, timeout, state[1:0]}
    assign dut_out = {PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, freeze_o, timeout_o, state_o};

    int passed = 0, total = 0;
    bit m_halted = 0;
    int m_streak = 0, m_stall = 0, m_flush = 0, m_freeze = 0;
    vec_t tbl[14];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic in_t mk(input logic mr, input int rd, input int rs1, input int rs2,
                               input logic br, input logic busy);
        in_t v;
        v.mr = mr; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.br = br; v.busy = busy;
        return v;
    endfunction

    // Expected outputs from the priority rules: HALT > busy > load-use > branch > default
    function automatic logic [7:0] model_out(input in_t v);
        logic lu;
        logic [1:0] st;
        lu = v.mr && v.rd != 0 && (v.rd == v.rs1 || v.rd == v.rs2);
        st = (m_streak > 0) ? 2'd1 : 2'd0;
        if (m_halted) return 8'b0000_1110;
        if (v.busy) return {6'b000010, st};
        if (lu) return {6'b000100, st};
        if (v.br) return {6'b111000, st};
        return {6'b110000, st};
    endfunction

    task automatic drive(input in_t v);
        IDEX_MemRead_i = v.mr; IDEX_RDaddr_i = v.rd; IFID_RS1addr_i = v.rs1;
        IFID_RS2addr_i = v.rs2; Branch_taken_i = v.br; mem_busy_i = v.busy;
    endtask

    task automatic cyc(input in_t v, input string nm, input bit has_exp, input logic [7:0] exp);
        logic [7:0] m;
        m = model_out(v);
        drive(v);
        @(negedge clk_i);
        if (has_exp) chk(nm, dut_out, exp);
        chk({nm, "_model"}, dut_out, m);
        @(posedge clk_i);
        #1;
        if (m[4]) m_stall++;
        if (m[5]) m_flush++;
        if (m[3]) m_freeze++;
        if (!m_halted) begin
            if (v.busy) begin
                m_streak++;
                if (m_streak >= MAXW) m_halted = 1;
            end else m_streak = 0;
        end
    endtask

    task automatic rst_pulse(input string nm);
        drive(mk(0, 0, 0, 0, 0, 0));
        rst_i = 1'b1;
        #2;
        chk(nm, dut_out, 8'b0001_0000);
        m_halted = 0; m_streak = 0; m_stall = 0; m_flush = 0; m_freeze = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic stats_chk(input string nm);
`ifdef PIPE_HAZARD_STATS_EN
        chk32({nm, "_stall"}, stall_cnt_o, 32'(m_stall));
        chk32({nm, "_flush"}, flush_cnt_o, 32'(m_flush));
        chk32({nm, "_freeze"}, freeze_cnt_o, 32'(m_freeze));
`else
        nm = nm;
`endif
    endtask

    initial begin
        in_t v;
        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0), 8'b1100_0000};
        tbl[1]  = '{mk(1, 5, 0, 5, 0, 0), 8'b0001_0000};
        tbl[2]  = '{mk(0, 5, 0, 5, 0, 0), 8'b1100_0000};
        tbl[3]  = '{mk(1, 0, 0, 3, 0, 0), 8'b1100_0000};
        tbl[4]  = '{mk(1, 7, 7, 3, 0, 0), 8'b0001_0000};
        tbl[5]  = '{mk(1, 7, 3, 4, 0, 0), 8'b1100_0000};
        tbl[6]  = '{mk(1, 5, 1, 5, 1, 0), 8'b0001_0000};
        tbl[7]  = '{mk(0, 5, 1, 5, 1, 0), 8'b1110_0000};
        tbl[8]  = '{mk(1, 5, 5, 0, 1, 1), 8'b0000_1000};
        tbl[9]  = '{mk(1, 5, 5, 0, 0, 0), 8'b0001_0001};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 0), 8'b1100_0000};
        tbl[11] = '{mk(0, 0, 0, 0, 1, 1), 8'b0000_1000};
        tbl[12] = '{mk(0, 0, 0, 0, 1, 0), 8'b1110_0001};
        tbl[13] = '{mk(0, 0, 0, 0, 0, 0), 8'b1100_0000};

        repeat (2) @(posedge clk_i);
        #1;
        rst_pulse("reset_out");
        stats_chk("reset_stats");

        for (int i = 0; i < 14; i++) cyc(tbl[i].in, $sformatf("tbl%0d", i), 1, tbl[i].exp);

        rst_pulse("reset_out2");
        cyc(mk(0, 0, 0, 0, 0, 1), "wait_run", 1, 8'b0000_1000);
        cyc(mk(0, 0, 0, 0, 0, 1), "wait_1", 1, 8'b0000_1001);
        cyc(mk(0, 0, 0, 0, 0, 1), "wait_2", 1, 8'b0000_1001);
        cyc(mk(0, 0, 0, 0, 0, 0), "wait_release", 1, 8'b1100_0001);
        cyc(mk(0, 0, 0, 0, 0, 0), "wait_back_run", 1, 8'b1100_0000);
`ifdef PIPE_HAZARD_STATS_EN
        chk32("wait_freeze_cnt", freeze_cnt_o, 32'd3);
`endif

        cyc(mk(0, 0, 0, 0, 0, 1), "to_run", 1, 8'b0000_1000);
        for (int i = 0; i < MAXW - 1; i++) cyc(mk(0, 0, 0, 0, 0, 1), $sformatf("to_wait%0d", i), 1, 8'b0000_1001);
        cyc(mk(0, 0, 0, 0, 0, 1), "to_halt", 1, 8'b0000_1110);
        cyc(mk(0, 0, 0, 0, 0, 0), "halt_idle", 1, 8'b0000_1110);
        cyc(mk(1, 5, 5, 0, 1, 0), "halt_ignore", 1, 8'b0000_1110);
        stats_chk("halt_stats");
        rst_pulse("halt_reset");
        cyc(mk(0, 0, 0, 0, 0, 0), "after_halt", 1, 8'b1100_0000);

        cyc(mk(0, 0, 0, 0, 0, 1), "mid_run", 1, 8'b0000_1000);
        cyc(mk(0, 0, 0, 0, 0, 1), "mid_wait", 1, 8'b0000_1001);
        rst_pulse("mid_reset");
        cyc(mk(0, 0, 0, 0, 0, 0), "mid_after", 1, 8'b1100_0000);
        cyc(mk(0, 0, 0, 0, 0, 1), "cnt_clr0", 1, 8'b0000_1000);
        cyc(mk(0, 0, 0, 0, 0, 1), "cnt_clr1", 1, 8'b0000_1001);
        cyc(mk(0, 0, 0, 0, 0, 1), "cnt_clr2", 1, 8'b0000_1001);
        cyc(mk(0, 0, 0, 0, 0, 0), "cnt_clr_rel", 1, 8'b1100_0001);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) rst_pulse("rnd_reset");
            v = mk(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 3) == 0);
            cyc(v, "rnd", 0, 8'h00);
        end
        stats_chk("final_stats");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
